// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan : multiplexed hex display scan driver
//
// Holds NDIG hex digits and presents them one slot at a time on x for a
// downstream combinational 4-bit -> 7-segment decoder.  It also drives the
// active-low digit anodes and decimal point.  Each slot starts with BLANK
// clocks of all-anodes-off to hide ghosting.  Optional leading-zero suppression
// is applied.  New display words enter through a load/ready handshake into a
// shadow register and are copied to the active register only at a frame end,
// so a frame is never drawn from two different words.
//
// Ports
//   clk     in   1        system clock, rising edge
//   rst     in   1        synchronous reset, active-high
//   load    in   1        request to capture data/dp_in
//   ready   out  1        1 = a load is accepted this cycle
//   data    in   4*NDIG   hex digits, digit k = data[4k+3:4k]
//   dp_in   in   NDIG     decimal point per digit, 1 = lit
//   lzs_en  in   1        leading-zero suppression enable (sampled live)
//   x       out  4        nibble for the segment decoder
//   an_n    out  NDIG     digit anodes, active-low, at most one low
//   dp_n    out  1        decimal point, active-low
//   slot    out  3        current digit index (debug)
// -----------------------------------------------------------------------------
module seg_scan #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  output logic              ready,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              lzs_en,
  output logic [3:0]        x,
  output logic [NDIG-1:0]   an_n,
  output logic              dp_n,
  output logic [2:0]        slot
);

  localparam int               CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]    DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]    BLANK_END = CW'(BLANK);
  localparam logic [2:0]       SLOT_LAST = 3'(NDIG - 1);

  // ---------------------------------------------------------------------------
  // Timebase: div_cnt walks through one slot, slot_cnt walks through a frame.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] div_cnt;
  logic [2:0]    slot_cnt;
  logic          slot_end;
  logic          frame_end;

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (slot_cnt == SLOT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      slot_cnt <= '0;
    end else if (slot_end) begin
      div_cnt  <= '0;
      slot_cnt <= (slot_cnt == SLOT_LAST) ? 3'd0 : slot_cnt + 3'd1;
    end else begin
      div_cnt  <= div_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and frame-aligned transfer.
  // ready is simply "nothing pending"; a capture and a transfer can never
  // coincide because a transfer needs pending=1, i.e. ready=0.
  // ---------------------------------------------------------------------------
  logic [4*NDIG-1:0] shadow_data;
  logic [NDIG-1:0]   shadow_dp;
  logic [4*NDIG-1:0] active_data;
  logic [NDIG-1:0]   active_dp;
  logic              pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      active_data <= '0;
      active_dp   <= '0;
      pending     <= 1'b0;
      ready       <= 1'b1;
    end else if (load && ready) begin
      shadow_data <= data;
      shadow_dp   <= dp_in;
      pending     <= 1'b1;
      ready       <= 1'b0;
    end else if (frame_end && pending) begin
      active_data <= shadow_data;
      active_dp   <= shadow_dp;
      pending     <= 1'b0;
      ready       <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero suppression per digit: digit k is suppressed when it and all
  // more significant digits are zero.  Digit 0 always shows, so a value of
  // zero displays as a single "0".
  // ---------------------------------------------------------------------------
  logic [NDIG-1:0] supp;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_supp
    if (gi == 0) begin : g_lsd
      assign supp[gi] = 1'b0;
    end else begin : g_upper
      assign supp[gi] = lzs_en && ~|active_data[4*NDIG-1:4*gi];
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection from the current (pre-edge) timebase, registered so the
  // pins lag the counters by exactly one clock.
  // ---------------------------------------------------------------------------
  logic [3:0]      x_next;
  logic            cur_dp;
  logic            cur_supp;
  logic            lit;
  logic [NDIG-1:0] an_n_next;
  logic            dp_n_next;

  always_comb begin
    x_next   = 4'd0;
    cur_dp   = 1'b0;
    cur_supp = 1'b0;
    // Mux by comparison rather than indexing so slot_cnt's fixed 3-bit width
    // never has to match the digit count.
    for (int k = 0; k < NDIG; k++) begin
      if (slot_cnt == 3'(k)) begin
        x_next   = active_data[4*k +: 4];
        cur_dp   = active_dp[k];
        cur_supp = supp[k];
      end
    end

    lit = (div_cnt >= BLANK_END) && !cur_supp;

    an_n_next = '1;
    for (int k = 0; k < NDIG; k++) begin
      if (lit && (slot_cnt == 3'(k))) begin
        an_n_next[k] = 1'b0;
      end
    end

    // The decimal point follows the anode so it cannot light a suppressed
    // or blanked digit.
    dp_n_next = lit ? ~cur_dp : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x    <= 4'd0;
      an_n <= '1;
      dp_n <= 1'b1;
      slot <= 3'd0;
    end else begin
      x    <= x_next;
      an_n <= an_n_next;
      dp_n <= dp_n_next;
      slot <= slot_cnt;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_scan : self-checking bench for seg_scan (NDIG=4, DIV=4, BLANK=1)
//
// The stimulus process drives inputs on the falling edge and, from a
// time-indexed reference model (cycle number since reset -> slot and position
// by division), pushes the outputs expected after the coming rising edge into
// a queue.  A separate monitor pops one entry per cycle just after each rising
// edge and compares every output field.
// -----------------------------------------------------------------------------
module tb_seg_scan;

  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = NDIG * DIV;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load = 1'b0;
  logic              ready;
  logic [4*NDIG-1:0] data = '0;
  logic [NDIG-1:0]   dp_in = '0;
  logic              lzs_en = 1'b0;
  logic [3:0]        x;
  logic [NDIG-1:0]   an_n;
  logic              dp_n;
  logic [2:0]        slot;

  seg_scan #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .ready  (ready),
    .data   (data),
    .dp_in  (dp_in),
    .lzs_en (lzs_en),
    .x      (x),
    .an_n   (an_n),
    .dp_n   (dp_n),
    .slot   (slot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready;
    logic [3:0] x;
    logic [3:0] an;
    logic       dp;
    logic [2:0] slot;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state (touched only by the stimulus process)
  int          t = 0;           // cycles since reset released
  logic        m_ready = 1'b1;
  logic [15:0] m_shadow_d = '0;
  logic [3:0]  m_shadow_dp = '0;
  logic [15:0] m_disp_d = '0;
  logic [3:0]  m_disp_dp = '0;
  logic        cur_lzs = 1'b0;

  // One clock: drive inputs, predict the post-edge outputs, queue them.
  task automatic step(input logic r, input logic ld, input logic [15:0] d,
                      input logic [3:0] dp);
    exp_t        e;
    int          s;
    int          pos;
    logic        supp;
    logic        lit;
    logic [15:0] upper;
    @(negedge clk);
    rst    = r;
    load   = ld;
    data   = d;
    dp_in  = dp;
    lzs_en = cur_lzs;
    if (r) begin
      e = '{ready: 1'b1, x: 4'h0, an: 4'hF, dp: 1'b1, slot: 3'd0};
      t = 0;
      m_ready = 1'b1;
      m_shadow_d = '0; m_shadow_dp = '0;
      m_disp_d = '0;   m_disp_dp = '0;
    end else begin
      s     = (t / DIV) % NDIG;
      pos   = t % DIV;
      upper = m_disp_d >> (4 * s);
      supp  = cur_lzs && (s > 0) && (upper == 16'h0);
      lit   = (pos >= BLANK) && !supp;
      e.x    = upper[3:0];
      e.an   = 4'hF;
      if (lit) e.an[s] = 1'b0;
      e.dp   = lit ? ~m_disp_dp[s] : 1'b1;
      e.slot = 3'(s);
      if (ld && m_ready) begin
        m_shadow_d = d; m_shadow_dp = dp; m_ready = 1'b0;
      end else if ((t % FRAME) == FRAME - 1 && !m_ready) begin
        m_disp_d = m_shadow_d; m_disp_dp = m_shadow_dp; m_ready = 1'b1;
      end
      e.ready = m_ready;
      t++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic idle_until_phase(input int ph);
    for (int i = 0; i < 4 * FRAME && (t % FRAME) != ph; i++) idle(1);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  // Monitor: one queued expectation per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ready", {7'd0, ready}, {7'd0, e.ready});
        check("x",     {4'd0, x},     {4'd0, e.x});
        check("an_n",  {4'd0, an_n},  {4'd0, e.an});
        check("dp_n",  {7'd0, dp_n},  {7'd0, e.dp});
        check("slot",  {5'd0, slot},  {5'd0, e.slot});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset and blank/lit timing of slot 0 with an all-zero word
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(20);

    // 2/3. mid-frame load, then an ignored load while pending
    idle_until_phase(5);
    step(1'b0, 1'b1, 16'h1A2B, 4'b0100);
    idle(3);
    step(1'b0, 1'b1, 16'hFFFF, 4'b1111);
    idle(3 * FRAME);

    // 4. leading-zero suppression on, then off
    cur_lzs = 1'b1;
    idle_until_phase(3);
    step(1'b0, 1'b1, 16'h0030, 4'b0000);
    idle(3 * FRAME);
    cur_lzs = 1'b0;
    idle(2 * FRAME);

    // 5. reset while a word is pending
    step(1'b0, 1'b1, 16'h7777, 4'b1010);
    idle(2);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(2 * FRAME);

    // 6. load exactly on the frame-end edge with ready=1
    idle_until_phase(FRAME - 1);
    step(1'b0, 1'b1, 16'h5555, 4'b0001);
    idle(3 * FRAME);

    // Randomized phase
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0) cur_lzs = ~cur_lzs;
      if ($urandom_range(0, 299) == 0)
        step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
      else begin
        logic [15:0] d;
        d = 16'($urandom);
        // Bias towards leading zeros so suppression is exercised often.
        case ($urandom_range(0, 3))
          0: d = d & 16'h00FF;
          1: d = d & 16'h000F;
          2: d = d & 16'h0FFF;
          default: ;
        endcase
        step(1'b0, ($urandom_range(0, 7) == 0), d, 4'($urandom));
      end
    end

    @(posedge clk);
    #2;
    check("drain", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
